// File: rtl/parity_serial_tx_9_bits_pkg.sv
// Shared definitions for the 9-bit parity serial transmitter.
//   state_t    : FSM state encoding (3 bits)
//   DATA_W     : payload width
//   FRAME_BITS : bit-periods per frame (start + data + parity + stop)
//   LINE_IDLE  : serial line level when idle / stop bit
//   START_BIT  : serial line level of the start bit
package parity_serial_tx_9_bits_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int   DATA_W     = 9;
    localparam int   FRAME_BITS = 12;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic START_BIT  = 1'b0;

endpackage

// File: rtl/parity_serial_tx_9_bits_if.sv
// Word handshake between the upstream parity stage and the transmitter.
//   in_data  : word to transmit
//   in_valid : in_data is valid
//   in_ready : transmitter can accept a word
// master = word source, slave = transmitter.
interface parity_serial_tx_9_bits_if;
    import parity_serial_tx_9_bits_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/parity_serial_tx_9_bits_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle tick on the last count of each bit period.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable; counter is held at 0 when low
//   tick       : high in the final cycle of each bit period
module parity_serial_tx_9_bits_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    // Width never drops below 1 so CLKS_PER_BIT==1 still has a legal vector;
    // in that case the counter sits at 0 and every enabled cycle is a tick.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] clk_cnt_q;

    assign tick = en && (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt_q <= '0;
        end else if (!en || tick) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_serial_tx_9_bits.sv
// Serialises a 9-bit word as: start(0), data[0..8] LSB first, parity, stop(1).
// Each bit is held for CLKS_PER_BIT clocks.
//   clk, rst_n  : clock, async active-low reset
//   in_if       : word handshake (slave side); in_ready == (state == IDLE)
//   tx_serial   : serial line, idles high
//   tx_busy     : high while a frame is in flight
//   frame_done  : one-cycle pulse in the final cycle of the stop bit
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (line low)
// DATA   | shifting data bits out LSB first
// PARITY | parity bit
// STOP   | stop bit (line high), frame_done in last cycle
module parity_serial_tx_9_bits
    import parity_serial_tx_9_bits_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    parity_serial_tx_9_bits_if.slave   in_if,
    output logic                       tx_serial,
    output logic                       tx_busy,
    output logic                       frame_done
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q;
    logic              par_q;
    logic [3:0]        bit_cnt_q;
    logic              bit_tick;
    logic              accept;

    assign in_if.in_ready = (state_q == ST_IDLE);
    assign accept         = in_if.in_valid && (state_q == ST_IDLE);

    parity_serial_tx_9_bits_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != ST_IDLE),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from registered state only, so in_* never reaches
    // tx_serial combinationally.
    always_comb begin
        state_d    = state_q;
        tx_serial  = LINE_IDLE;
        tx_busy    = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_busy = 1'b0;
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                tx_serial = START_BIT;
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_serial = shreg_q[0];
                if (bit_tick && (bit_cnt_q == 4'(DATA_W - 1))) state_d = ST_PARITY;
            end
            ST_PARITY: begin
                tx_serial = par_q;
                if (bit_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                tx_serial  = LINE_IDLE;
                frame_done = bit_tick;
                if (bit_tick) state_d = ST_IDLE;
            end
            default: begin
                tx_busy = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word and parity are captured once at acceptance; later in_data changes
    // cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
        end else if (accept) begin
            shreg_q   <= in_if.in_data;
            par_q     <= (^in_if.in_data) ^ PARITY_ODD;
            bit_cnt_q <= '0;
        end else if ((state_q == ST_DATA) && bit_tick) begin
            shreg_q   <= {1'b0, shreg_q[DATA_W-1:1]};
            bit_cnt_q <= (bit_cnt_q == 4'(DATA_W - 1)) ? 4'd0 : bit_cnt_q + 4'd1;
        end
    end

endmodule
